// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory bus of the two-port dmem arbiter
interface dmem_arbiter_if #(
    parameter int RegBits = 32
);
    logic [1:0]           req_i;
    logic [1:0]           we_i;
    logic [2*RegBits-1:0] addr_i;
    logic [2*RegBits-1:0] wdata_i;
    logic [1:0]           gnt_o;
    logic [1:0]           rvalid_o;
    logic [RegBits-1:0]   rdata_o;
    logic                 err_o;
    logic [RegBits-1:0]   mem_a_o;
    logic [RegBits-1:0]   mem_wd_o;
    logic                 mem_we_o;
    logic [RegBits-1:0]   mem_rd_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_rd_i,
        output gnt_o, rvalid_o, rdata_o, err_o, mem_a_o, mem_wd_o, mem_we_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_rd_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, mem_a_o, mem_wd_o, mem_we_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter for a single-ported data memory
module dmem_arbiter #(
    parameter int RegBits  = 32,
    parameter int MemBytes = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    localparam logic [RegBits-1:0] MaxAddr = RegBits'(MemBytes - 4);

    state_t               state;
    logic                 rr;
    logic                 lat_port;
    logic                 lat_we;
    logic [RegBits-1:0]   lat_addr;
    logic [RegBits-1:0]   lat_wdata;
    logic [RegBits-1:0]   rdata_q;
    logic                 err_q;

    logic                 any_req;
    logic                 sel;
    logic                 sel_we;
    logic [RegBits-1:0]   sel_addr;
    logic [RegBits-1:0]   sel_wdata;
    logic                 in_range;

    // A lone requester wins outright; contention is settled by the rr pointer.
    always_comb begin
        any_req = |bus.req_i;
        if (bus.req_i == 2'b11) begin
            sel = rr;
        end else begin
            sel = bus.req_i[1];
        end
        sel_we    = sel ? bus.we_i[1] : bus.we_i[0];
        sel_addr  = sel ? bus.addr_i[2*RegBits-1:RegBits]  : bus.addr_i[RegBits-1:0];
        sel_wdata = sel ? bus.wdata_i[2*RegBits-1:RegBits] : bus.wdata_i[RegBits-1:0];
    end

    // Word access must fit entirely inside memory; unaligned is fine.
    assign in_range = (lat_addr <= MaxAddr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr        <= 1'b0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_port  <= sel;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    rdata_q <= (in_range && !lat_we) ? bus.mem_rd_i : '0;
                    err_q   <= !in_range;
                    state   <= RESP;
                end
                RESP: begin
                    rr    <= ~rr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o    = (state == IDLE && any_req && !rst_i) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rvalid_o = (state == RESP) ? (lat_port ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rdata_o  = (state == RESP) ? rdata_q : '0;
    assign bus.err_o    = (state == RESP) && err_q;
    assign bus.mem_a_o  = lat_addr;
    assign bus.mem_wd_o = lat_wdata;
    assign bus.mem_we_o = (state == SERVE) && lat_we && in_range;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a byte-addressed memory model
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.RegBits(32)) bus();

    dmem_arbiter #(.RegBits(32), .MemBytes(1024)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [7:0]  mem [0:1023];

    function automatic logic [9:0] ix(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + 32'(k);
        return s[9:0];
    endfunction

    assign bus.mem_rd_i = {mem[ix(bus.mem_a_o, 3)], mem[ix(bus.mem_a_o, 2)],
                           mem[ix(bus.mem_a_o, 1)], mem[ix(bus.mem_a_o, 0)]};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            wr_count = wr_count + 1;
            last_wa  = bus.mem_a_o;
            last_wd  = bus.mem_wd_o;
            for (int k = 0; k < 4; k++) mem[ix(bus.mem_a_o, k)] = bus.mem_wd_o[8*k +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completion is matched against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && bus.rvalid_o != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid", {62'd0, bus.rvalid_o}, {62'd0, e.rv});
                check("rdata", {32'd0, bus.rdata_o}, {32'd0, e.rd});
                check("err", {63'd0, bus.err_o}, {63'd0, e.err});
            end
        end
    end

    function automatic exp_t mk(input int p, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rv  = (p == 1) ? 2'b10 : 2'b01;
        e.rd  = rd;
        e.err = err;
        return e;
    endfunction

    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.we_i[p]               = w;
        bus.addr_i[p*32 +: 32]    = a;
        bus.wdata_i[p*32 +: 32]   = d;
        bus.req_i[p]              = 1'b1;
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd, input logic eerr);
        bit got;
        got = 1'b0;
        drive(p, w, a, d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.gnt_o[p]) got = 1'b1;
        end
        if (got) sb.push_back(mk(p, erd, eerr));
        check("grant_wait", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        bus.req_i[p] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("drain", {63'd0, (sb.size() == 0)}, 64'd1);
        @(posedge clk); #1;
    endtask

    int wc0;
    int g;
    int last_c;
    bit got;

    initial begin
        bus.req_i   = 2'b00;
        bus.we_i    = 2'b00;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {62'd0, bus.gnt_o}, 64'd0);
        check("rst_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
        check("rst_rdata", {32'd0, bus.rdata_o}, 64'd0);
        check("rst_err", {63'd0, bus.err_o}, 64'd0);
        check("rst_mem_we", {63'd0, bus.mem_we_o}, 64'd0);
        check("rst_mem_a", {32'd0, bus.mem_a_o}, 64'd0);
        check("rst_mem_wd", {32'd0, bus.mem_wd_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read back on port 0.
        wc0 = wr_count;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        drain();
        check("wr10_count", 64'(wr_count - wc0), 64'd1);
        check("wr10_addr", {32'd0, last_wa}, 64'h10);
        check("wr10_data", {32'd0, last_wd}, 64'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        drain();

        // Range boundary on port 1.
        wc0 = wr_count;
        issue(1, 1'b1, 32'h3FD, 32'hA5A5A5A5, 32'h0, 1'b1);
        drain();
        check("oor_no_write", 64'(wr_count - wc0), 64'd0);
        issue(1, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
        drain();
        check("edge_write", 64'(wr_count - wc0), 64'd1);
        check("edge_addr", {32'd0, last_wa}, 64'h3FC);
        issue(1, 1'b0, 32'h3FD, 32'h0, 32'h0, 1'b1);
        issue(1, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);
        drain();

        // Unaligned write/read.
        issue(0, 1'b1, 32'h21, 32'h11223344, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h21, 32'h0, 32'h11223344, 1'b0);
        drain();

        // Port 0 pulses a request only during RESP of a port 1 read.
        wc0 = wr_count;
        drive(1, 1'b0, 32'h10, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.gnt_o[1]) got = 1'b1;
        end
        check("p1_grant", {63'd0, got}, 64'd1);
        if (got) sb.push_back(mk(1, 32'hDEADBEEF, 1'b0));
        @(posedge clk); #1;
        bus.req_i[1] = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h40, 32'h77777777);
        @(negedge clk);
        check("resp_no_grant", {62'd0, bus.gnt_o}, 64'd0);
        @(posedge clk); #1;
        bus.req_i[0] = 1'b0;
        @(negedge clk);
        check("dropped_no_grant", {62'd0, bus.gnt_o}, 64'd0);
        drain();
        repeat (3) @(posedge clk); #1;
        check("dropped_no_write", 64'(wr_count - wc0), 64'd0);

        // Both ports hammer reads straight out of reset.
        rst = 1'b1;
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h21, 32'h0);
        @(negedge clk);
        check("rst_req_gnt", {62'd0, bus.gnt_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        g = 0;
        last_c = 0;
        for (int c = 0; c < 40 && g < 4; c++) begin
            @(negedge clk);
            if (bus.gnt_o != 2'b00) begin
                check("alt_gnt", {62'd0, bus.gnt_o}, (g % 2 == 0) ? 64'd1 : 64'd2);
                if (g == 0) check("alt_first_cycle", 64'(c), 64'd0);
                else check("alt_spacing", 64'(c - last_c), 64'd3);
                if (g % 2 == 0) sb.push_back(mk(0, 32'hDEADBEEF, 1'b0));
                else sb.push_back(mk(1, 32'h11223344, 1'b0));
                last_c = c;
                g++;
            end
        end
        check("alt_count", 64'(g), 64'd4);
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        drain();

        // Leave rr pointing at port 1, then abort a write with reset mid-SERVE.
        issue(1, 1'b0, 32'h21, 32'h0, 32'h11223344, 1'b0);
        drain();
        wc0 = wr_count;
        drive(0, 1'b1, 32'h80, 32'h55555555);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.gnt_o[0]) got = 1'b1;
        end
        check("abort_grant", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_i = 2'b00;
        @(negedge clk);
        check("abort_gnt", {62'd0, bus.gnt_o}, 64'd0);
        check("abort_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
        check("abort_rdata", {32'd0, bus.rdata_o}, 64'd0);
        check("abort_err", {63'd0, bus.err_o}, 64'd0);
        check("abort_mem_we", {63'd0, bus.mem_we_o}, 64'd0);
        check("abort_mem_a", {32'd0, bus.mem_a_o}, 64'd0);
        check("abort_mem_wd", {32'd0, bus.mem_wd_o}, 64'd0);
        drive(0, 1'b0, 32'h80, 32'h0);
        drive(1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", {62'd0, bus.gnt_o}, 64'd1);
        if (bus.gnt_o == 2'b01) sb.push_back(mk(0, 32'h0, 1'b0));
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        drain();
        check("abort_no_write", 64'(wr_count - wc0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter RegBits, default 32, giving the data/address width.
REQ-002 The block SHALL have parameter MemBytes, default 1024, giving the data-memory size in bytes.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  2  per-port request; bit p = port p (port 0 = core load/store, port 1 = DMA/debug).
REQ-006 we_i  input  2  per-port write (1) / read (0) qualifier, valid while req_i[p]=1.
REQ-007 addr_i  input  2*RegBits  per-port byte address; port p at [p*RegBits +: RegBits].
REQ-008 wdata_i  input  2*RegBits  per-port write data; port p at [p*RegBits +: RegBits].
REQ-009 gnt_o  output  2  per-port acceptance strobe, one-hot or zero.
REQ-010 rvalid_o  output  2  per-port completion strobe, one-hot or zero.
REQ-011 rdata_o  output  RegBits  read data for the completing port, shared by both ports.
REQ-012 err_o  output  1  completion error flag, valid when rvalid_o is non-zero.
REQ-013 mem_a_o  output  RegBits  data-memory byte address.
REQ-014 mem_wd_o  output  RegBits  data-memory write data.
REQ-015 mem_we_o  output  1  data-memory write enable.
REQ-016 mem_rd_i  input  RegBits  data-memory combinational read data for mem_a_o.

Function
REQ-017 Control SHALL be a 3-state FSM: IDLE, SERVE, RESP; every access takes exactly IDLE->SERVE->RESP->IDLE.
REQ-018 IDLE: if req_i!=0, select a port and assert gnt_o[p] combinationally in that cycle; latch port, we, addr, wdata on the same edge; next state SERVE; else remain IDLE, gnt_o=0.
REQ-019 Selection: single requester wins; both requesting -> port equal to rr pointer wins.
REQ-020 rr pointer SHALL toggle to the other port at the RESP->IDLE edge of every access, whichever port was served.
REQ-021 SERVE: mem_a_o=latched addr, mem_wd_o=latched wdata, mem_we_o=latched we AND in-range; read data mem_rd_i captured into rdata register at the SERVE->RESP edge.
REQ-022 In-range: latched addr <= MemBytes-4 (unsigned, full RegBits compare); unaligned in-range addresses SHALL be legal.
REQ-023 Out-of-range: mem_we_o SHALL stay 0, captured rdata SHALL be 0, err flag SHALL be set.
REQ-024 RESP: rvalid_o[p]=1 for exactly one cycle, rdata_o=captured data (0 for writes), err_o=err flag; err_o=0 whenever rvalid_o=0.
REQ-025 Outside SERVE, mem_we_o SHALL be 0; mem_a_o/mem_wd_o SHALL hold the latched values.
REQ-026 Latency: grant in cycle N, memory write at edge ending N+1, rvalid_o in cycle N+2; max throughput one access per 3 cycles.
REQ-027 Requests arriving in SERVE or RESP SHALL NOT be granted; requester holds req_i, we_i, addr_i, wdata_i stable until gnt_o.
REQ-028 req_i dropped before grant SHALL be ignored with no side effects.
REQ-029 A port SHALL be granted at most once per access; a non-selected requester is granted no later than the next IDLE (starvation bound 3 cycles).

Reset
REQ-030 rst_i=1 SHALL asynchronously force: state IDLE, rr pointer=0, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, mem_we_o=0, mem_a_o=0, mem_wd_o=0, all latches 0.
REQ-031 Reset asserted in SERVE or RESP SHALL abort the access: no write occurs after assertion, no rvalid_o is issued.
REQ-032 After deassertion the first grant SHALL occur no earlier than the first rising edge with rst_i=0.

Verification
REQ-033 Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> mem_we_o=1 one cycle with mem_a_o=0x10; read rvalid_o=01, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Both ports request reads every cycle from reset -> grants alternate 01,10,01,10 at 3-cycle spacing.
REQ-035 Port 1 write addr 0x3FD (MemBytes=1024) -> mem_we_o stays 0, rvalid_o=10, err_o=1, rdata_o=0; addr 0x3FC -> accepted, err_o=0.
REQ-036 Reset pulse during SERVE of a write -> no mem_we_o edge, rvalid_o stays 0, all outputs 0, next grant goes to port 0.
REQ-037 Port 0 req for one cycle during RESP then dropped -> no grant, no memory activity.
REQ-038 Unaligned write addr 0x21 data 0x11223344 then read 0x21 -> rdata_o=0x11223344, err_o=0.
